// File: rtl/sdc_pkg.sv
// sdc_pkg: shared state encoding, error codes and SD bus byte constants for the SD command sequencer
package sdc_pkg;
  typedef enum logic [2:0] {IDLE, PRE, CMD, R1, TOKEN, DATA, CRC, TAIL} state_t;
  typedef enum logic [1:0] {ERR_OK, ERR_R1, ERR_TOKEN, ERR_DATA} err_t;
  localparam logic [7:0] START_TOKEN = 8'hFE;
  localparam logic [7:0] IDLE_BYTE = 8'hFF;
endpackage

// File: rtl/sdc_crc7.sv
// sdc_crc7: byte-serial SD CRC7 (x^7+x^3+1), MSB first
//   clk, rst (async active-low), clr: zero the crc, valid: fold data into crc
//   data[7:0]: byte being sent, crc[6:0]: running remainder
module sdc_crc7 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       valid,
  input  logic [7:0] data,
  output logic [6:0] crc
);
  logic [6:0] nxt;
  always_comb begin
    nxt = crc;
    for (int i = 7; i >= 0; i--) nxt = {nxt[5:0], 1'b0} ^ ({7{nxt[6] ^ data[i]}} & 7'h09);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) crc <= '0;
    else if (clr) crc <= '0;
    else if (valid) crc <= nxt;
endmodule

// File: rtl/sdc_cmd.sv
// sdc_cmd: SD command/R1/single-block-read sequencer driving a byte/word SPI shift engine
//   host side : cmd_valid/cmd_ready/cmd_idx/cmd_arg/cmd_rd in, resp_valid/resp_r1, data_valid/data_word, done/err out
//   engine    : spi_start/spi_fast/spi_tx out, spi_rx/spi_rdy in; cs_n drives the card chip select
//   clk, rst (async active-low)
module sdc_cmd
  import sdc_pkg::*;
#(
  parameter int RESP_TRIES  = 8,
  parameter int TOKEN_TRIES = 4096,
  parameter int WORDS       = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_rd,
  output logic        resp_valid,
  output logic [7:0]  resp_r1,
  output logic        data_valid,
  output logic [31:0] data_word,
  output logic        done,
  output logic [1:0]  err,
  output logic        cs_n,
  output logic        spi_fast,
  output logic        spi_start,
  output logic [31:0] spi_tx,
  input  logic [31:0] spi_rx,
  input  logic        spi_rdy
);
  localparam int CW = $clog2(TOKEN_TRIES);
  state_t state, state_nx;
  logic busy, busy_nx, cs_nx, start_nx, fast_nx, rv_nx, dv_nx, done_nx, rd, rd_nx;
  logic crc_clr, crc_vld;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0] tx_nx, word_nx, arg, arg_nx;
  logic [7:0] r1_nx, cmd_byte, cur_byte;
  logic [5:0] idx, idx_nx;
  logic [6:0] crc;
  logic [1:0] err_nx;
  assign cmd_ready = state == IDLE && !done;
  assign cmd_byte = cnt == CW'(0) ? {2'b01, idx} :
                    cnt == CW'(1) ? arg[31:24] :
                    cnt == CW'(2) ? arg[23:16] :
                    cnt == CW'(3) ? arg[15:8] :
                    cnt == CW'(4) ? arg[7:0] : {crc, 1'b1};
  assign cur_byte = state == CMD ? cmd_byte : IDLE_BYTE;
  sdc_crc7 u_crc (
    .clk(clk), .rst(rst), .clr(crc_clr), .valid(crc_vld), .data(cur_byte), .crc(crc)
  );
  always_comb begin
    state_nx = state;
    busy_nx  = busy;
    cnt_nx   = cnt;
    cs_nx    = cs_n;
    start_nx = 1'b0;
    fast_nx  = spi_fast;
    tx_nx    = spi_tx;
    rv_nx    = 1'b0;
    r1_nx    = resp_r1;
    dv_nx    = 1'b0;
    word_nx  = data_word;
    done_nx  = 1'b0;
    err_nx   = err;
    idx_nx   = idx;
    arg_nx   = arg;
    rd_nx    = rd;
    crc_clr  = 1'b0;
    crc_vld  = 1'b0;
    if (state == IDLE) begin
      if (cmd_valid && cmd_ready) begin
        idx_nx   = cmd_idx;
        arg_nx   = cmd_arg;
        rd_nx    = cmd_rd;
        crc_clr  = 1'b1;
        cs_nx    = 1'b0;
        cnt_nx   = '0;
        err_nx   = ERR_OK;
        state_nx = PRE;
      end
    end else if (!busy) begin
      if (spi_rdy) begin
        start_nx = 1'b1;
        busy_nx  = 1'b1;
        fast_nx  = state == DATA;
        tx_nx    = state == DATA ? '1 : {24'hFFFFFF, cur_byte};
        crc_vld  = state == CMD && cnt < CW'(5);
      end
    end else if (!spi_start && spi_rdy) begin
      // rdy is still high during the start-pulse cycle; completion is only trusted after that
      busy_nx = 1'b0;
      case (state)
        PRE: begin
          state_nx = CMD;
          cnt_nx   = '0;
        end
        CMD: begin
          cnt_nx   = cnt == CW'(5) ? '0 : cnt + 1'b1;
          state_nx = cnt == CW'(5) ? R1 : CMD;
        end
        R1:
          if (!spi_rx[7]) begin
            rv_nx    = 1'b1;
            r1_nx    = spi_rx[7:0];
            cnt_nx   = '0;
            state_nx = rd && spi_rx[7:0] == 8'h00 ? TOKEN : TAIL;
          end else if (cnt == CW'(RESP_TRIES - 1)) begin
            rv_nx    = 1'b1;
            r1_nx    = IDLE_BYTE;
            err_nx   = ERR_R1;
            state_nx = TAIL;
          end else cnt_nx = cnt + 1'b1;
        TOKEN:
          if (spi_rx[7:0] == START_TOKEN) begin
            cnt_nx   = '0;
            state_nx = DATA;
          end else if (spi_rx[7:0] != IDLE_BYTE) begin
            err_nx   = ERR_DATA;
            state_nx = TAIL;
          end else if (cnt == CW'(TOKEN_TRIES - 1)) begin
            err_nx   = ERR_TOKEN;
            state_nx = TAIL;
          end else cnt_nx = cnt + 1'b1;
        DATA: begin
          dv_nx    = 1'b1;
          word_nx  = spi_rx;
          cnt_nx   = cnt == CW'(WORDS - 1) ? '0 : cnt + 1'b1;
          fast_nx  = cnt != CW'(WORDS - 1);
          state_nx = cnt == CW'(WORDS - 1) ? CRC : DATA;
        end
        CRC: begin
          cnt_nx   = cnt == CW'(1) ? '0 : cnt + 1'b1;
          state_nx = cnt == CW'(1) ? TAIL : CRC;
        end
        TAIL: begin
          cs_nx    = 1'b1;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      cnt        <= '0;
      cs_n       <= 1'b1;
      spi_start  <= 1'b0;
      spi_fast   <= 1'b0;
      spi_tx     <= '1;
      resp_valid <= 1'b0;
      resp_r1    <= IDLE_BYTE;
      data_valid <= 1'b0;
      data_word  <= '0;
      done       <= 1'b0;
      err        <= ERR_OK;
      idx        <= '0;
      arg        <= '0;
      rd         <= 1'b0;
    end else begin
      state      <= state_nx;
      busy       <= busy_nx;
      cnt        <= cnt_nx;
      cs_n       <= cs_nx;
      spi_start  <= start_nx;
      spi_fast   <= fast_nx;
      spi_tx     <= tx_nx;
      resp_valid <= rv_nx;
      resp_r1    <= r1_nx;
      data_valid <= dv_nx;
      data_word  <= word_nx;
      done       <= done_nx;
      err        <= err_nx;
      idx        <= idx_nx;
      arg        <= arg_nx;
      rd         <= rd_nx;
    end
endmodule

// File: tb/tb_sdc_cmd.sv
// tb_sdc_cmd: randomized bench for sdc_cmd with a scripted SD card and SPI engine model
module tb_sdc_cmd;
  localparam int RT = 8;
  localparam int TT = 4096;
  localparam int NW = 128;
  logic clk, rst, cmd_valid, cmd_ready, cmd_rd, resp_valid, data_valid, done, cs_n, spi_fast, spi_start, spi_rdy;
  logic [5:0] cmd_idx;
  logic [31:0] cmd_arg, data_word, spi_tx, spi_rx;
  logic [7:0] resp_r1;
  logic [1:0] err;
  logic [32:0] exp_tx[$], got_q[$];
  logic got_cs[$];
  logic [31:0] card_q[$], exp_words[$];
  logic [7:0] exp_r1;
  logic [1:0] exp_err, done_err;
  logic done_cs, done_rdy, done_fast, eng_busy, h_fast;
  logic [31:0] h_tx;
  int checks, failures, dv_cnt, rv_cnt, done_cnt, coinc, stab_viol, start_viol, lat, exp_nw;
  sdc_cmd dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_idx(cmd_idx),
    .cmd_arg(cmd_arg), .cmd_rd(cmd_rd), .resp_valid(resp_valid), .resp_r1(resp_r1),
    .data_valid(data_valid), .data_word(data_word), .done(done), .err(err), .cs_n(cs_n),
    .spi_fast(spi_fast), .spi_start(spi_start), .spi_tx(spi_tx), .spi_rx(spi_rx), .spi_rdy(spi_rdy)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction
  task automatic put(input logic [7:0] txb, input logic [7:0] rxb);
    exp_tx.push_back({1'b0, 24'hFFFFFF, txb});
    card_q.push_back({24'($urandom), rxb});
  endtask
  // reference: the full MOSI byte/word sequence and card MISO script of one transaction
  task automatic build(input logic [5:0] idx, input logic [31:0] arg, input bit rd, input int r1_pos,
                       input logic [7:0] r1, input int tok_pre, input logic [7:0] tok, input bit seqw);
    logic [39:0] m;
    logic [31:0] w;
    int polls;
    exp_tx.delete(); card_q.delete(); exp_words.delete(); exp_nw = 0;
    m = {2'b01, idx, arg};
    put(8'hFF, 8'($urandom));
    for (int i = 0; i < 5; i++) put(m[39-8*i -: 8], 8'($urandom));
    put({crc7_ref(m), 1'b1}, 8'($urandom));
    polls = r1_pos >= RT ? RT : r1_pos + 1;
    for (int i = 0; i < polls; i++) put(8'hFF, i < r1_pos ? 8'hFF : r1);
    if (r1_pos >= RT) begin
      exp_r1 = 8'hFF; exp_err = 2'd1;
    end else begin
      exp_r1 = r1; exp_err = 2'd0;
      if (rd && r1 == 8'h00) begin
        if (tok_pre >= TT) begin
          for (int i = 0; i < TT; i++) put(8'hFF, 8'hFF);
          exp_err = 2'd2;
        end else begin
          for (int i = 0; i < tok_pre; i++) put(8'hFF, 8'hFF);
          put(8'hFF, tok);
          if (tok == 8'hFE) begin
            for (int i = 0; i < NW; i++) begin
              w = seqw ? 32'(i) : $urandom;
              exp_tx.push_back({1'b1, 32'hFFFFFFFF});
              card_q.push_back(w);
              exp_words.push_back(w);
              exp_nw++;
            end
            put(8'hFF, 8'($urandom));
            put(8'hFF, 8'($urandom));
          end else exp_err = 2'd3;
        end
      end
    end
    put(8'hFF, 8'($urandom));
  endtask
  // SPI engine + card + output monitors, all sampled on the falling edge
  initial begin
    spi_rdy = 1'b1; spi_rx = '0; eng_busy = 1'b0; lat = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        spi_rdy = 1'b1; eng_busy = 1'b0;
      end else begin
        if (spi_start) begin
          if (!spi_rdy) start_viol++;
          else begin
            got_q.push_back({spi_fast, spi_tx}); got_cs.push_back(cs_n);
            h_tx = spi_tx; h_fast = spi_fast; spi_rdy = 1'b0; eng_busy = 1'b1;
            lat = $urandom_range(1, 3);
          end
        end else if (eng_busy) begin
          if (spi_tx !== h_tx || spi_fast !== h_fast) stab_viol++;
          lat--;
          if (lat == 0) begin
            spi_rx = card_q.size() != 0 ? card_q.pop_front() : $urandom;
            spi_rdy = 1'b1; eng_busy = 1'b0;
          end
        end
        if (data_valid) begin
          dv_cnt++;
          if (exp_words.size() == 0) check("data_extra", 1, 0);
          else check("data_word", data_word, exp_words.pop_front());
        end
        if (resp_valid) begin
          rv_cnt++;
          check("resp_r1", resp_r1, exp_r1);
        end
        if (done) begin
          done_cnt++;
          if (resp_valid) coinc++;
          done_err = err; done_cs = cs_n; done_rdy = cmd_ready; done_fast = spi_fast;
        end
      end
    end
  end
  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit rd, input int r1_pos,
                           input logic [7:0] r1, input int tok_pre, input logic [7:0] tok, input bit seqw,
                           input bit noise);
    int n;
    build(idx, arg, rd, r1_pos, r1, tok_pre, tok, seqw);
    got_q.delete(); got_cs.delete();
    dv_cnt = 0; rv_cnt = 0; done_cnt = 0; coinc = 0;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); #1; n++; end
    check("ready_before", cmd_ready, 1);
    cmd_idx = idx; cmd_arg = arg; cmd_rd = rd; cmd_valid = 1'b1;
    @(negedge clk); #1;
    cmd_valid = noise; cmd_idx = ~idx; cmd_arg = ~arg; cmd_rd = ~rd;
  endtask
  task automatic finish_cmd();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 50000) begin @(negedge clk); #1; n++; end
    cmd_valid = 1'b0;
    check("done_seen", done_cnt, 1);
    check("ready_in_done", done_rdy, 0);
    check("err", done_err, exp_err);
    check("cs_at_done", done_cs, 1);
    check("fast_at_done", done_fast, 0);
    check("resp_once", rv_cnt, 1);
    check("resp_done_overlap", coinc, 0);
    check("data_count", dv_cnt, exp_nw);
    check("xfer_count", got_q.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < got_q.size(); i++) begin
      check("xfer_tx", got_q[i], exp_tx[i]);
      check("xfer_cs", got_cs[i], 0);
    end
    @(negedge clk); #1;
    check("ready_after", cmd_ready, 1);
    check("done_single", done_cnt, 1);
    check("cs_idle", cs_n, 1);
    check("tx_stable", stab_viol, 0);
    check("start_rules", start_viol, 0);
  endtask
  initial begin
    logic [79:0] mosi0;
    int n, kind;
    checks = 0; failures = 0; stab_viol = 0; start_viol = 0;
    rst = 1'b0; cmd_valid = 1'b0; cmd_idx = '0; cmd_arg = '0; cmd_rd = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs", cs_n, 1);
    check("rst_start", spi_start, 0);
    check("rst_fast", spi_fast, 0);
    check("rst_tx", spi_tx, 32'hFFFFFFFF);
    check("rst_resp", {resp_valid, resp_r1}, 9'h0FF);
    check("rst_data", {data_valid, data_word}, 33'h0);
    check("rst_done", {done, err}, 3'b000);
    rst = 1'b1;
    @(negedge clk); #1;
    check("ready_idle", cmd_ready, 1);
    start_cmd(6'd0, 32'h0, 1'b0, 1, 8'h01, 0, 8'h00, 1'b0, 1'b0);
    finish_cmd();
    mosi0 = 80'hFF_40_00_00_00_00_95_FF_FF_FF;
    check("cmd0_len", got_q.size(), 10);
    for (int i = 0; i < 10 && i < got_q.size(); i++) check("cmd0_mosi", got_q[i][7:0], mosi0[79-8*i -: 8]);
    start_cmd(6'd8, 32'h000001AA, 1'b0, 0, 8'h01, 0, 8'h00, 1'b0, 1'b1);
    finish_cmd();
    if (got_q.size() > 6) check("cmd8_crc", got_q[6][7:0], 8'h87);
    else check("cmd8_len", got_q.size(), 10);
    start_cmd(6'd17, 32'h10, 1'b1, 0, 8'h00, 3, 8'hFE, 1'b1, 1'b0);
    finish_cmd();
    start_cmd(6'd17, 32'h10, 1'b1, RT, 8'h00, 0, 8'hFE, 1'b0, 1'b0);
    finish_cmd();
    start_cmd(6'd17, 32'h200, 1'b1, 1, 8'h00, 2, 8'h08, 1'b0, 1'b0);
    finish_cmd();
    start_cmd(6'd17, 32'h400, 1'b1, 0, 8'h00, TT, 8'hFE, 1'b0, 1'b0);
    finish_cmd();
    start_cmd(6'd17, 32'h20, 1'b1, 0, 8'h00, 1, 8'hFE, 1'b0, 1'b0);
    n = 0;
    while (dv_cnt < 40 && n < 5000) begin @(negedge clk); #1; n++; end
    check("reach_word40", dv_cnt, 40);
    #2 rst = 1'b0;
    #1;
    check("arst_cs", cs_n, 1);
    check("arst_start", spi_start, 0);
    repeat (3) @(negedge clk);
    #1;
    check("arst_no_done", done_cnt, 0);
    check("arst_outs", {resp_r1, err, spi_fast, data_valid}, 12'hFF0);
    @(negedge clk);
    rst = 1'b1;
    start_cmd(6'd0, 32'h0, 1'b0, 0, 8'h01, 0, 8'h00, 1'b0, 1'b0);
    finish_cmd();
    for (int t = 0; t < 12; t++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: start_cmd(6'($urandom), $urandom, 1'b0, $urandom_range(0, 3), 8'($urandom_range(0, 127)), 0, 8'hFE, 1'b0, 1'($urandom));
        1: start_cmd(6'($urandom), $urandom, 1'b1, $urandom_range(0, 3), 8'h00, $urandom_range(0, 6), 8'hFE, 1'b0, 1'($urandom));
        2: start_cmd(6'($urandom), $urandom, 1'b1, $urandom_range(0, 7), 8'($urandom_range(1, 127)), 0, 8'hFE, 1'b0, 1'($urandom));
        3: start_cmd(6'($urandom), $urandom, 1'($urandom), RT, 8'h00, 0, 8'hFE, 1'b0, 1'($urandom));
        default: start_cmd(6'($urandom), $urandom, 1'b1, 0, 8'h00, $urandom_range(0, 6), 8'($urandom_range(0, 253)), 1'b0, 1'($urandom));
      endcase
      finish_cmd();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
